// File: rtl/food.sv
// Food generator and eat detector for the snake game.
// Consumes the body scanner's segment stream, places food at a pseudo-random
// interior cell, confirms over one full scan that the body does not cover it,
// then watches for the head landing on it and pulses o_eat.
module food #(
    parameter int unsigned X_MAX = 20,
    parameter int unsigned Y_MAX = 11,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_pos_x,
    input  logic [3:0] i_pos_y,
    input  logic       i_pos_first,
    input  logic       i_pos_last,
    input  logic       i_pos_valid,
    input  logic       i_entropy,
    output logic       o_eat,
    output logic [4:0] o_food_x,
    output logic [3:0] o_food_y,
    output logic       o_food_valid,
    output logic [7:0] o_score
);

    typedef enum logic [1:0] {StSearch, StCheck, StActive} state_e;

    localparam logic [4:0]  XMax     = 5'(X_MAX);
    localparam logic [3:0]  YMax     = 4'(Y_MAX);
    localparam logic [15:0] LfsrMask = 16'hB400;

    state_e      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic        eat_q;
    logic [4:0]  food_x_q;
    logic [3:0]  food_y_q;
    logic        food_valid_q;
    logic [7:0]  score_q;
    logic        hit_q;

    logic        feedback;
    logic [15:0] lfsr_step;
    logic [4:0]  rx, cand_x;
    logic [3:0]  ry, cand_y;
    logic        scan_start, scan_end;
    logic        cand_hit, food_hit, hit_acc;

    // Galois LFSR next state; entropy is folded into the feedback bit, and the
    // all-zero lock-up state is replaced by the seed.
    always_comb begin
        feedback  = lfsr_q[0] ^ i_entropy;
        lfsr_step = {1'b0, lfsr_q[15:1]} ^ ({16{feedback}} & LfsrMask);
        lfsr_d    = (lfsr_step == 16'h0000) ? SEED : lfsr_step;
    end

    // Fold raw LFSR bits into the interior; one subtraction suffices because
    // the raw range is less than twice the interior size.
    always_comb begin
        rx       = lfsr_q[4:0];
        ry       = lfsr_q[8:5];
        cand_x   = ((rx < XMax) ? rx : (rx - XMax)) + 5'd1;
        cand_y   = ((ry < YMax) ? ry : (ry - YMax)) + 4'd1;
        scan_start = i_pos_valid & i_pos_first;
        scan_end   = i_pos_valid & i_pos_last;
        cand_hit   = (i_pos_x == cand_x) && (i_pos_y == cand_y);
        food_hit   = (i_pos_x == food_x_q) && (i_pos_y == food_y_q);
        hit_acc    = hit_q | food_hit;
    end

    // Placement/eat FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSearch;
            lfsr_q       <= SEED;
            eat_q        <= 1'b0;
            food_x_q     <= 5'd0;
            food_y_q     <= 4'd0;
            food_valid_q <= 1'b0;
            score_q      <= 8'd0;
            hit_q        <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            eat_q  <= 1'b0;
            unique case (state_q)
                StSearch, StCheck: begin
                    // A start seen mid-check is a protocol error: recapture as from search.
                    if (scan_start) begin
                        food_x_q <= cand_x;
                        food_y_q <= cand_y;
                        hit_q    <= cand_hit;
                        if (scan_end) begin
                            state_q      <= cand_hit ? StSearch : StActive;
                            food_valid_q <= ~cand_hit;
                        end else begin
                            state_q <= StCheck;
                        end
                    end else if (state_q == StCheck && i_pos_valid) begin
                        hit_q <= hit_acc;
                        if (scan_end) begin
                            state_q      <= hit_acc ? StSearch : StActive;
                            food_valid_q <= ~hit_acc;
                        end
                    end
                end
                StActive: begin
                    if (scan_start && food_hit) begin
                        eat_q        <= 1'b1;
                        food_valid_q <= 1'b0;
                        state_q      <= StSearch;
                        if (score_q != 8'hFF) begin
                            score_q <= score_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

    assign o_eat        = eat_q;
    assign o_food_x     = food_x_q;
    assign o_food_y     = food_y_q;
    assign o_food_valid = food_valid_q;
    assign o_score      = score_q;

endmodule

// File: tb/tb_food.sv
// Self-checking bench for food: a reference model predicts every registered
// output per cycle into a scoreboard; directed checks cover the key scenarios.
module tb_food;

    localparam int          X_MAX = 20;
    localparam int          Y_MAX = 11;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] i_pos_x = 5'd0;
    logic [3:0] i_pos_y = 4'd0;
    logic       i_pos_first = 1'b0;
    logic       i_pos_last = 1'b0;
    logic       i_pos_valid = 1'b0;
    logic       i_entropy = 1'b0;
    logic       o_eat;
    logic [4:0] o_food_x;
    logic [3:0] o_food_y;
    logic       o_food_valid;
    logic [7:0] o_score;

    food #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pos_x     (i_pos_x),
        .i_pos_y     (i_pos_y),
        .i_pos_first (i_pos_first),
        .i_pos_last  (i_pos_last),
        .i_pos_valid (i_pos_valid),
        .i_entropy   (i_entropy),
        .o_eat       (o_eat),
        .o_food_x    (o_food_x),
        .o_food_y    (o_food_y),
        .o_food_valid(o_food_valid),
        .o_score     (o_score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       eat;
        logic [4:0] fx;
        logic [3:0] fy;
        logic       fv;
        logic [7:0] score;
    } obs_t;

    obs_t        sb_q[$];
    logic [15:0] m_lfsr;
    int          m_st;      // 0 search, 1 check, 2 active
    logic [4:0]  m_fx;
    logic [3:0]  m_fy;
    logic        m_hit, m_fv, m_eat;
    logic [7:0]  m_score;
    int          checks = 0;
    int          failures = 0;
    logic [4:0]  seg_x[$];
    logic [3:0]  seg_y[$];

    function automatic logic [4:0] cand_x(input logic [15:0] l);
        return 5'((int'(l[4:0]) % X_MAX) + 1);
    endfunction

    function automatic logic [3:0] cand_y(input logic [15:0] l);
        return 4'((int'(l[8:5]) % Y_MAX) + 1);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l, input logic e);
        logic [15:0] n;
        n = l >> 1;
        if (l[0] ^ e) n = n ^ 16'hB400;
        if (n == 16'h0000) n = SEED;
        return n;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_st = 0; m_fx = 5'd0; m_fy = 4'd0;
        m_hit = 1'b0; m_fv = 1'b0; m_eat = 1'b0; m_score = 8'd0;
    endtask

    task automatic model(input logic [4:0] x, input logic [3:0] y,
                         input logic f, input logic l, input logic v);
        logic start, fin, h;
        start = v && f;
        fin   = v && l;
        m_eat = 1'b0;
        if (start && m_st != 2) begin
            m_fx = cand_x(m_lfsr);
            m_fy = cand_y(m_lfsr);
            h = (x == m_fx) && (y == m_fy);
            m_hit = h;
            if (fin) begin m_st = h ? 0 : 2; m_fv = !h; end
            else m_st = 1;
        end else if (m_st == 1 && v) begin
            m_hit = m_hit || ((x == m_fx) && (y == m_fy));
            if (fin) begin m_st = m_hit ? 0 : 2; m_fv = !m_hit; end
        end else if (m_st == 2 && start && x == m_fx && y == m_fy) begin
            m_eat = 1'b1;
            m_fv  = 1'b0;
            m_st  = 0;
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input logic [4:0] x, input logic [3:0] y,
                        input logic f, input logic l, input logic v, input logic e);
        obs_t exp, act;
        i_pos_x = x; i_pos_y = y; i_pos_first = f; i_pos_last = l;
        i_pos_valid = v; i_entropy = e;
        model(x, y, f, l, v);
        sb_q.push_back({m_eat, m_fx, m_fy, m_fv, m_score});
        @(posedge clk);
        m_lfsr = lfsr_next(m_lfsr, e);
        #1;
        exp = sb_q.pop_front();
        act = {o_eat, o_food_x, o_food_y, o_food_valid, o_score};
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL cycle: got eat=%0d food=(%0d,%0d) valid=%0d score=%0d expected eat=%0d food=(%0d,%0d) valid=%0d score=%0d",
                   act.eat, act.fx, act.fy, act.fv, act.score,
                   exp.eat, exp.fx, exp.fy, exp.fv, exp.score);
        end
    endtask

    // Drive the queued segments as one scan, followed by one idle cycle.
    task automatic scan(input logic e);
        int n;
        n = seg_x.size();
        for (int i = 0; i < n; i++) begin
            step(seg_x[i], seg_y[i], i == 0, i == n - 1, 1'b1, e);
        end
        step(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic load_snake();
        seg_x = '{5'd10, 5'd9, 5'd8, 5'd7, 5'd6};
        seg_y = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    endtask

    initial begin
        logic [4:0] cx, hx;
        logic [3:0] cy;
        logic       e, rose;
        int         eats;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({o_eat, o_food_x, o_food_y, o_food_valid, o_score}), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Collision on the tail cycle
        cx = cand_x(m_lfsr); cy = cand_y(m_lfsr);
        hx = (cx == 5'd1) ? 5'd2 : 5'd1;
        step(hx, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("seed_capture", 32'({o_food_x, o_food_y}), 32'({5'd2, 4'd8}));
        step(hx, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(cx, cy, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("tail_collision_invalid", 32'(o_food_valid), 32'd0);
        step(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Collision on the head cycle
        cx = cand_x(m_lfsr); cy = cand_y(m_lfsr);
        hx = (cx == 5'd1) ? 5'd2 : 5'd1;
        step(cx, cy, 1'b1, 1'b0, 1'b1, 1'b0);
        step(hx, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("head_collision_invalid", 32'(o_food_valid), 32'd0);

        // Free placement with a straight snake, retried until clean
        load_snake();
        for (int i = 0; i < 30 && !m_fv; i++) scan(1'b0);
        chk("free_placement", 32'(o_food_valid), 32'd1);

        // Body segment on food with head elsewhere: no eat
        hx = (m_fx == 5'd1) ? 5'd2 : 5'd1;
        seg_x = '{hx, m_fx, hx};
        seg_y = '{4'd1, m_fy, 4'd2};
        scan(1'b0);
        chk("body_no_eat_score", 32'(o_score), 32'd0);
        chk("body_no_eat_valid", 32'(o_food_valid), 32'd1);

        // Head on food: eat
        step(m_fx, m_fy, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("eat_pulse", 32'(o_eat), 32'd1);
        chk("eat_score", 32'(o_score), 32'd1);
        chk("eat_clears_valid", 32'(o_food_valid), 32'd0);
        step(hx, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("eat_one_cycle", 32'(o_eat), 32'd0);

        // Length-0 scans and score saturation
        eats = 0;
        for (int i = 0; i < 256; i++) begin
            e  = 1'($urandom_range(1));
            cx = cand_x(m_lfsr);
            hx = (cx == 5'd1) ? 5'd2 : 5'd1;
            step(hx, 4'd1, 1'b1, 1'b1, 1'b1, e);
            chk("len0_valid", 32'(o_food_valid), 32'd1);
            step(m_fx, m_fy, 1'b1, 1'b1, 1'b1, 1'($urandom_range(1)));
            eats = eats + int'(o_eat);
        end
        chk("score_saturated", 32'(o_score), 32'd255);
        chk("eat_pulse_count", 32'(eats), 32'd256);

        // Full board: every candidate collides
        rose = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int yy = 1; yy <= Y_MAX; yy++) begin
                for (int xx = 1; xx <= X_MAX; xx++) begin
                    step(5'(xx), 4'(yy), (xx == 1) && (yy == 1),
                         (xx == X_MAX) && (yy == Y_MAX), 1'b1, 1'($urandom_range(1)));
                    rose = rose | o_food_valid;
                end
            end
        end
        chk("full_board_no_food", 32'(rose), 32'd0);

        // Asynchronous reset mid-check
        step(5'd3, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({o_eat, o_food_x, o_food_y, o_food_valid, o_score}), 32'd0);
        i_pos_valid = 1'b0;
        i_pos_first = 1'b0;
        i_pos_last  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        load_snake();
        scan(1'b0);
        chk("post_reset_capture", 32'({o_food_x, o_food_y}), 32'({5'd2, 4'd8}));
        chk("post_reset_valid", 32'(o_food_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
